fifo_byte_stream: RTL

Parametrised byte-serialising FIFO: accepts multi-byte writes of variable width (1..MAX_BYTES bytes per cycle) and presents them one byte at a time on a first-word-fall-through read port with an `ack` pop handshake. It sits between the packet/format logic and the UART transmitter, generalising the fixed 2-byte front buffer plus side memory into a single circular byte store. It adds configurable depth, configurable write width, level/space reporting and overflow detection.

---
 rtl/fifo_byte_stream.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fifo_byte_stream.sv
// fifo_byte_stream
//
// Byte-serialising FIFO. Each cycle it accepts a write of 1..MAX_BYTES
// bytes and presents the stored bytes one at a time on a
// first-word-fall-through read port. The read port pops with `ack`.
// Storage is a single circular byte array of DEPTH entries.
//
// Ordering: the most significant used byte of a write is sent first.
//
// Build option:
//   FIFO_BYTE_STREAM_PARTIAL_WRITE_EN
//     defined     : a write larger than the free space stores the first
//                   `free` bytes in send order and drops the rest.
//     not defined : a write larger than the free space is dropped whole.
//   `overflow` pulses for one cycle on such a write in either build.
//
// Parameters:
//   MAX_BYTES  maximum bytes per write (>= 1)
//   DEPTH      storage in bytes (power of two, >= MAX_BYTES, >= 2)
//
// Ports:
//   clk_i         clock, rising edge
//   reset_i       synchronous active-high reset
//   write_enable  write strobe
//   write_data    payload; the low write_width bytes are used
//   write_width   bytes in this write; 0 is a no-op; > MAX_BYTES clamps
//   write_ready   at least MAX_BYTES bytes free
//   overflow      one-cycle pulse, the cycle after a truncated or dropped write
//   level         bytes currently stored
//   ack           pop the head byte (ignored while empty)
//   data          head byte, 8'h00 while empty
//   have_next     data is valid

// One write lane: places byte k of the current write at wp+k.
module fifo_byte_stream_lane #(
  parameter int MAX_BYTES = 4,
  parameter int DEPTH     = 64,
  parameter int LANE      = 0,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(MAX_BYTES) + 1
) (
  input  logic [PW-1:0]          wp,
  input  logic [CW-1:0]          w_eff,
  input  logic [CW-1:0]          acc,
  input  logic [MAX_BYTES*8-1:0] write_data,
  output logic                   we,
  output logic [PW-1:0]          addr,
  output logic [7:0]             wbyte
);
  localparam logic [CW-1:0] K = CW'(LANE);

  logic [CW-1:0] sel;

  // Only the first `acc` bytes in send order are stored; this lane is
  // byte k in send order.
  assign we   = K < acc;
  assign addr = wp + PW'(LANE);
  // Send order is MSB-first, so lane k takes payload byte (w-1-k).
  assign sel  = w_eff - K - CW'(1);

  always_comb begin
    wbyte = 8'h00;
    for (int j = 0; j < MAX_BYTES; j++)
      if (CW'(j) == sel) wbyte = write_data[j*8 +: 8];
  end
endmodule

module fifo_byte_stream #(
  parameter int MAX_BYTES = 4,
  parameter int DEPTH     = 64,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1,
  localparam int CW = $clog2(MAX_BYTES) + 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   write_enable,
  input  logic [MAX_BYTES*8-1:0] write_data,
  input  logic [CW-1:0]          write_width,
  output logic                   write_ready,
  output logic                   overflow,
  output logic [LW-1:0]          level,
  input  logic                   ack,
  output logic [7:0]             data,
  output logic                   have_next
);
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [LW-1:0] free;
  logic [CW-1:0] w_eff, acc;
  logic          ovf_req, pop;

  logic [MAX_BYTES-1:0]         lane_we;
  logic [MAX_BYTES-1:0][PW-1:0] lane_addr;
  logic [MAX_BYTES-1:0][7:0]    lane_byte;

  // Space is judged on the registered level only; a same-cycle pop does
  // not make room for this cycle's write.
  assign free        = LW'(DEPTH) - level;
  assign write_ready = free >= LW'(MAX_BYTES);
  assign have_next   = level != '0;
  assign data        = have_next ? mem[rp] : 8'h00;
  assign pop         = ack & have_next;

  always_comb begin
    w_eff = '0;
    if (write_enable)
      w_eff = (write_width > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : write_width;
  end

  assign ovf_req = 32'(w_eff) > 32'(free);

`ifdef FIFO_BYTE_STREAM_PARTIAL_WRITE_EN
  // Overflow implies free < w_eff <= MAX_BYTES, so free fits in CW bits.
  assign acc = ovf_req ? CW'(free) : w_eff;
`else
  assign acc = ovf_req ? '0 : w_eff;
`endif

  genvar g;
  generate
    for (g = 0; g < MAX_BYTES; g++) begin : g_lane
      fifo_byte_stream_lane #(
        .MAX_BYTES (MAX_BYTES),
        .DEPTH     (DEPTH),
        .LANE      (g)
      ) u_lane (
        .wp         (wp),
        .w_eff      (w_eff),
        .acc        (acc),
        .write_data (write_data),
        .we         (lane_we[g]),
        .addr       (lane_addr[g]),
        .wbyte      (lane_byte[g])
      );
    end
  endgenerate

  // Lane addresses are distinct because MAX_BYTES <= DEPTH.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < MAX_BYTES; k++)
      if (lane_we[k] && !reset_i) mem[lane_addr[k]] <= lane_byte[k];
  end

  // Pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wp       <= '0;
      rp       <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      wp       <= wp + PW'(acc);
      rp       <= rp + PW'(pop);
      level    <= level + LW'(acc) - LW'(pop);
      overflow <= ovf_req;
    end
  end
endmodule
